// File: rtl/vc_circular_buffer.sv
// Multi-VC router input buffer: one circular FIFO per virtual channel, registered
// single-port read, per-VC full/empty and hysteretic on/off credit back-pressure.
module vc_circular_buffer #(
  parameter int FLIT_W   = 32,
  parameter int NUM_VC   = 4,
  parameter int BUF_SIZE = 8,
  parameter int OFF_TH   = 6,
  parameter int ON_TH    = 3,
  localparam int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int PTR_W   = $clog2(BUF_SIZE),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] input_Data,
  input  logic              write_i,
  input  logic [VC_W-1:0]   write_vc_i,
  input  logic              read_i,
  input  logic [VC_W-1:0]   read_vc_i,
  output logic [FLIT_W-1:0] output_Data,
  output logic              output_valid,
  output logic [NUM_VC-1:0] buf_empty,
  output logic [NUM_VC-1:0] buf_full,
  output logic [NUM_VC-1:0] buf_On_Off,
  output logic              overflow_o,
  output logic              underflow_o
);

  logic [FLIT_W-1:0] mem [NUM_VC][BUF_SIZE];
  logic [PTR_W-1:0]  wr_ptr [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr [NUM_VC];
  logic [CNT_W-1:0]  count [NUM_VC];
  logic [CNT_W-1:0]  count_nxt [NUM_VC];
  logic [NUM_VC-1:0] wr_sel, rd_sel, on_off;
  logic [FLIT_W-1:0] rd_data_p0;
  logic              wr_any, rd_any;

  // Stage 0: accept decisions. An index that matches no VC selects nothing, so
  // out-of-range requests fall through to the drop/ignore path.
  always_comb begin
    rd_sel     = '0;
    wr_sel     = '0;
    rd_data_p0 = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (read_i && (read_vc_i == VC_W'(v)) && (count[v] != '0)) begin
        rd_sel[v]  = 1'b1;
        rd_data_p0 = mem[v][rd_ptr[v]];
      end
    end
    // A full VC still takes a write when the same cycle frees one of its slots.
    for (int v = 0; v < NUM_VC; v++) begin
      if (write_i && (write_vc_i == VC_W'(v)) &&
          ((count[v] != CNT_W'(BUF_SIZE)) || rd_sel[v]))
        wr_sel[v] = 1'b1;
    end
    for (int v = 0; v < NUM_VC; v++) begin
      count_nxt[v] = count[v];
      case ({wr_sel[v], rd_sel[v]})
        2'b10:   count_nxt[v] = count[v] + 1'b1;
        2'b01:   count_nxt[v] = count[v] - 1'b1;
        default: count_nxt[v] = count[v];
      endcase
    end
  end

  assign wr_any = |wr_sel;
  assign rd_any = |rd_sel;

  always_comb begin
    buf_empty = '0;
    buf_full  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      buf_empty[v] = (count[v] == '0);
      buf_full[v]  = (count[v] == CNT_W'(BUF_SIZE));
    end
  end

  assign buf_On_Off = on_off;

  // Stage 1: pointer, occupancy, credit and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end
      on_off       <= '1;
      output_Data  <= '0;
      output_valid <= 1'b0;
      overflow_o   <= 1'b0;
      underflow_o  <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_sel[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (rd_sel[v]) rd_ptr[v] <= rd_ptr[v] + 1'b1;
        count[v] <= count_nxt[v];
        // Hysteresis keeps the credit line from chattering around one threshold.
        if (on_off[v]) begin
          if (count_nxt[v] >= CNT_W'(OFF_TH)) on_off[v] <= 1'b0;
        end else begin
          if (count_nxt[v] <= CNT_W'(ON_TH)) on_off[v] <= 1'b1;
        end
      end
      output_valid <= rd_any;
      if (rd_any) output_Data <= rd_data_p0;
      if (write_i && !wr_any) overflow_o  <= 1'b1;
      if (read_i && !rd_any)  underflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_sel[v]) mem[v][wr_ptr[v]] <= input_Data;
    end
  end

endmodule

// File: tb/tb_vc_circular_buffer.sv
// Bench for vc_circular_buffer: directed scenarios plus randomized traffic checked
// against a per-VC queue model.
module tb_vc_circular_buffer;
  localparam int FLIT_W = 32, NUM_VC = 4, BUF_SIZE = 8, OFF_TH = 6, ON_TH = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [FLIT_W-1:0] input_Data;
  logic              write_i, read_i;
  logic [1:0]        write_vc_i, read_vc_i;
  logic [FLIT_W-1:0] output_Data;
  logic              output_valid, overflow_o, underflow_o;
  logic [NUM_VC-1:0] buf_empty, buf_full, buf_On_Off;

  vc_circular_buffer #(.FLIT_W(FLIT_W), .NUM_VC(NUM_VC), .BUF_SIZE(BUF_SIZE),
                       .OFF_TH(OFF_TH), .ON_TH(ON_TH)) dut (
    .clk(clk), .rst(rst), .input_Data(input_Data), .write_i(write_i),
    .write_vc_i(write_vc_i), .read_i(read_i), .read_vc_i(read_vc_i),
    .output_Data(output_Data), .output_valid(output_valid),
    .buf_empty(buf_empty), .buf_full(buf_full), .buf_On_Off(buf_On_Off),
    .overflow_o(overflow_o), .underflow_o(underflow_o));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per VC plus the observable flags.
  logic [FLIT_W-1:0] mq [NUM_VC][$];
  logic [FLIT_W-1:0] m_data;
  logic              m_vld, m_ovf, m_unf;
  logic [NUM_VC-1:0] m_onoff;

  function automatic logic [NUM_VC-1:0] m_empty();
    for (int v = 0; v < NUM_VC; v++) m_empty[v] = (mq[v].size() == 0);
  endfunction

  function automatic logic [NUM_VC-1:0] m_full();
    for (int v = 0; v < NUM_VC; v++) m_full[v] = (mq[v].size() == BUF_SIZE);
  endfunction

  task automatic model_clear();
    for (int v = 0; v < NUM_VC; v++) mq[v].delete();
    m_data = '0; m_vld = 0; m_ovf = 0; m_unf = 0; m_onoff = '1;
  endtask

  task automatic do_reset();
    write_i = 0; read_i = 0;
    rst = 1'b1;
    model_clear();
    #3 rst = 1'b0;
  endtask

  // Drives one cycle of requests, advances the model at the clock edge, and
  // returns 1 ns after the edge with requests idled.
  task automatic step(input logic w, input int wvc, input logic [FLIT_W-1:0] d,
                      input logic r, input int rvc);
    bit rok, wok;
    write_i = w; write_vc_i = wvc[1:0]; input_Data = d;
    read_i = r;  read_vc_i = rvc[1:0];
    rok = r && (rvc < NUM_VC) && (mq[rvc].size() > 0);
    wok = w && (wvc < NUM_VC) && ((mq[wvc].size() < BUF_SIZE) || (rok && rvc == wvc));
    @(posedge clk);
    m_vld = rok;
    if (rok) m_data = mq[rvc].pop_front();
    else if (r) m_unf = 1;
    if (wok) mq[wvc].push_back(d);
    else if (w) m_ovf = 1;
    for (int v = 0; v < NUM_VC; v++) begin
      if (m_onoff[v] && mq[v].size() >= OFF_TH) m_onoff[v] = 0;
      else if (!m_onoff[v] && mq[v].size() <= ON_TH) m_onoff[v] = 1;
    end
    #1;
    write_i = 0; read_i = 0;
  endtask

  task automatic test_reset();
    total++;
    if ({output_Data, output_valid} !== {32'h0, 1'b0} || buf_empty !== 4'hF ||
        buf_full !== 4'h0 || buf_On_Off !== 4'hF || {overflow_o, underflow_o} !== 2'b00) begin
      bad++;
      $display("FAIL reset_state: data=%h vld=%b empty=%b full=%b onoff=%b ovf=%b unf=%b",
               output_Data, output_valid, buf_empty, buf_full, buf_On_Off, overflow_o, underflow_o);
    end
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) step(1, 1, 32'h100 + i, 0, 0);
    step(0, 0, 0, 1, 1);
    total++;
    if (buf_empty[1] !== 1'b0 || buf_On_Off[1] !== 1'b1) begin
      bad++;
      $display("FAIL prefill_vc1: empty=%b onoff=%b", buf_empty, buf_On_Off);
    end
    rst = 1'b1;
    model_clear();
    #1;
    total++;
    if (buf_empty !== 4'hF || buf_On_Off !== 4'hF || output_valid !== 1'b0 ||
        output_Data !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: empty=%b onoff=%b vld=%b data=%h",
               buf_empty, buf_On_Off, output_valid, output_Data);
    end
    #2 rst = 1'b0;
    step(0, 0, 0, 1, 1);
    total++;
    if (output_valid !== 1'b0 || underflow_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_count_zero: vld=%b unf=%b want 0 1", output_valid, underflow_o);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 32'hA0 + i, 0, 0);
    total++;
    if (buf_full !== 4'b0001 || overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL fill8: full=%b ovf=%b want 0001 0", buf_full, overflow_o);
    end
    step(1, 0, 32'hFF, 0, 0);
    total++;
    if (overflow_o !== 1'b1 || buf_full[0] !== 1'b1) begin
      bad++;
      $display("FAIL ninth_write: ovf=%b full=%b", overflow_o, buf_full);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0);
      total++;
      if (output_valid !== 1'b1 || output_Data !== 32'hA0 + i) begin
        bad++;
        $display("FAIL drain_%0d: vld=%b data=%h want 1 %h", i, output_valid, output_Data, 32'hA0 + i);
      end
    end
    step(0, 0, 0, 0, 0);
    total++;
    if (output_valid !== 1'b0 || output_Data !== 32'hA7 || buf_empty[0] !== 1'b1) begin
      bad++;
      $display("FAIL drain_idle: vld=%b data=%h empty=%b", output_valid, output_Data, buf_empty);
    end
  endtask

  task automatic test_wrap();
    logic [FLIT_W-1:0] exp_q[$];
    do_reset();
    for (int round = 0; round < 2; round++) begin
      int n = (round == 0) ? 6 : 8;
      for (int i = 0; i < n; i++) begin
        logic [FLIT_W-1:0] d = $urandom;
        exp_q.push_back(d);
        step(1, 2, d, 0, 0);
      end
      total++;
      if (buf_full[2] !== (n == 8) || buf_empty[2] !== 1'b0) begin
        bad++;
        $display("FAIL wrap_fill_%0d: full=%b empty=%b", round, buf_full, buf_empty);
      end
      for (int i = 0; i < n; i++) begin
        logic [FLIT_W-1:0] e = exp_q.pop_front();
        step(0, 0, 0, 1, 2);
        total++;
        if (output_valid !== 1'b1 || output_Data !== e) begin
          bad++;
          $display("FAIL wrap_read_%0d_%0d: vld=%b data=%h want %h", round, i, output_valid, output_Data, e);
        end
      end
      total++;
      if (buf_empty[2] !== 1'b1 || buf_full[2] !== 1'b0) begin
        bad++;
        $display("FAIL wrap_empty_%0d: empty=%b full=%b", round, buf_empty, buf_full);
      end
    end
  endtask

  task automatic test_hysteresis();
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      step(1, 3, $urandom, 0, 0);
      total++;
      if (buf_On_Off[3] !== (c < OFF_TH)) begin
        bad++;
        $display("FAIL hyst_up_%0d: onoff3=%b want %b", c, buf_On_Off[3], c < OFF_TH);
      end
    end
    for (int c = 5; c >= 3; c--) begin
      step(0, 0, 0, 1, 3);
      total++;
      if (buf_On_Off[3] !== (c <= ON_TH)) begin
        bad++;
        $display("FAIL hyst_down_%0d: onoff3=%b want %b", c, buf_On_Off[3], c <= ON_TH);
      end
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 32'hC0 + i, 0, 0);
    step(1, 0, 32'hCAFE, 1, 0);
    total++;
    if (overflow_o !== 1'b0 || buf_full[0] !== 1'b1 || output_valid !== 1'b1 ||
        output_Data !== 32'hC0) begin
      bad++;
      $display("FAIL full_rw: ovf=%b full=%b vld=%b data=%h want 0 1 1 c0",
               overflow_o, buf_full[0], output_valid, output_Data);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    total++;
    if (output_Data !== 32'hCAFE || buf_empty[0] !== 1'b1) begin
      bad++;
      $display("FAIL full_rw_tail: data=%h empty=%b want cafe 1", output_Data, buf_empty[0]);
    end
  endtask

  task automatic test_underflow_concurrent();
    do_reset();
    step(1, 1, 32'h11, 1, 1);
    total++;
    if (underflow_o !== 1'b1 || output_valid !== 1'b0 || buf_empty[1] !== 1'b0 ||
        overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL empty_rw: unf=%b vld=%b empty=%b ovf=%b", underflow_o, output_valid, buf_empty, overflow_o);
    end
    step(1, 2, 32'h22, 0, 0);
    step(1, 0, 32'h33, 1, 2);
    total++;
    if (output_Data !== 32'h22 || output_valid !== 1'b1 || buf_empty !== 4'b1100) begin
      bad++;
      $display("FAIL cross_vc: data=%h vld=%b empty=%b want 22 1 1100", output_Data, output_valid, buf_empty);
    end
    step(0, 0, 0, 1, 1);
    total++;
    if (output_Data !== 32'h11 || buf_empty[1] !== 1'b1) begin
      bad++;
      $display("FAIL vc1_single: data=%h empty=%b want 11", output_Data, buf_empty);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic w = ($urandom_range(0, 99) < 60);
      logic r = ($urandom_range(0, 99) < 45);
      int wv = $urandom_range(0, NUM_VC - 1);
      int rv = (n % 3 == 0) ? wv : $urandom_range(0, NUM_VC - 1);
      step(w, wv, $urandom, r, rv);
      total++;
      if (output_valid !== m_vld || output_Data !== m_data || buf_empty !== m_empty() ||
          buf_full !== m_full() || buf_On_Off !== m_onoff || overflow_o !== m_ovf ||
          underflow_o !== m_unf) begin
        bad++;
        $display("FAIL rand_%0d: vld=%b/%b data=%h/%h empty=%b/%b full=%b/%b onoff=%b/%b ovf=%b/%b unf=%b/%b",
                 n, output_valid, m_vld, output_Data, m_data, buf_empty, m_empty(),
                 buf_full, m_full(), buf_On_Off, m_onoff, overflow_o, m_ovf, underflow_o, m_unf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; write_i = 0; read_i = 0; write_vc_i = 0; read_vc_i = 0; input_Data = 0;
    model_clear();
    #12;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_hysteresis();
    test_full_rw();
    test_underflow_concurrent();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
